// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO.
package sync_fifo_pkg;

   localparam int FIFO_DATA_W_DEF   = 8;
   localparam int FIFO_DEPTH_DEF    = 8;
   localparam int FIFO_AF_LEVEL_DEF = 6;
   localparam int FIFO_AE_LEVEL_DEF = 2;

   // Occupancy counter width: must hold 0..depth inclusive.
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // True when depth is a power of two and at least 2.
   function automatic bit fifo_is_pow2(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_param_mem.sv
// DEPTH x DATA_W storage array: one synchronous write port, one asynchronous read port.
module fifo_mem_dp
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W_DEF,
   parameter int DEPTH  = FIFO_DEPTH_DEF,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write the addressed entry on an accepted write.
   // NOTE: the array has no reset; its contents are never observable until written.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : fifo_mem_dp

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost
// thresholds, overflow/underflow pulses and standard or FWFT read mode.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W   = FIFO_DATA_W_DEF,
   parameter int DEPTH    = FIFO_DEPTH_DEF,
   parameter int AF_LEVEL = FIFO_AF_LEVEL_DEF,
   parameter int AE_LEVEL = FIFO_AE_LEVEL_DEF,
   parameter int FWFT     = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         write_e,
   input  logic                         read_e,
   input  logic [DATA_W-1:0]            data_in,
   output logic [DATA_W-1:0]            data_out,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [fifo_cnt_w(DEPTH)-1:0] count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = fifo_cnt_w(DEPTH);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

   // Elaboration-time parameter legality.
   if (!fifo_is_pow2(DEPTH)) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two >= 2");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
   end
   if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
   end
   if (DATA_W < 1) begin : g_bad_w
      $error("sync_fifo_param: DATA_W must be >= 1");
   end
   if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
      $error("sync_fifo_param: FWFT must be 0 or 1");
   end

   logic [PTR_W-1:0]  wr_ptr_d, wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_d, rd_ptr_q;
   logic [CNT_W-1:0]  count_d, count_q;
   logic              overflow_d, overflow_q;
   logic              underflow_d, underflow_q;
   logic              rd_ok, wr_ok;
   logic [DATA_W-1:0] mem_rdata;

   // Status flags decode only from the registered count, so no request
   // input ever reaches an output combinationally.
   assign empty        = (count_q == '0);
   assign full         = (count_q == DEPTH_C);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
   assign rd_ok = read_e & ~empty;
   assign wr_ok = write_e & (~full | rd_ok);

   // Next-state for pointers, occupancy and error pulses.
   // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = write_e & ~wr_ok;
      underflow_d = read_e & ~rd_ok;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (wr_ok && !rd_ok) begin
         count_d = count_q + CNT_W'(1);
      end else if (rd_ok && !wr_ok) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // State registers with asynchronous reset.
   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_mem_dp #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );

   if (FWFT == 0) begin : g_std
      logic [DATA_W-1:0] dout_d, dout_q;

      // Load the output register on an accepted read, otherwise hold.
      always_comb begin
         dout_d = dout_q;
         if (rd_ok) begin
            dout_d = mem_rdata;
         end
      end

      // Registered read data, cleared by reset.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            dout_q <= '0;
         end else begin
            dout_q <= dout_d;
         end
      end

      assign data_out = dout_q;
   end else begin : g_fwft
      // Head word shown directly; zero while empty so stale memory never leaks.
      assign data_out = empty ? '0 : mem_rdata;
   end

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: default FIFO (standard read) and a 4x16 FWFT FIFO,
// both compared against a queue-based reference model every cycle.
module tb_sync_fifo_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // Instance 0: defaults (DATA_W=8, DEPTH=8, AF=6, AE=2, FWFT=0)
   logic       w0, r0;
   logic [7:0] di0, do0;
   logic       full0, empty0, af0, ae0, ovf0, udf0;
   logic [3:0] cnt0;

   // Instance 1: DATA_W=16, DEPTH=4, AF=3, AE=1, FWFT=1
   logic        w1, r1;
   logic [15:0] di1, do1;
   logic        full1, empty1, af1, ae1, ovf1, udf1;
   logic [2:0]  cnt1;

   sync_fifo_param u_dut0 (
      .clk          (clk),
      .reset        (reset),
      .write_e      (w0),
      .read_e       (r0),
      .data_in      (di0),
      .data_out     (do0),
      .full         (full0),
      .empty        (empty0),
      .almost_full  (af0),
      .almost_empty (ae0),
      .count        (cnt0),
      .overflow     (ovf0),
      .underflow    (udf0)
   );

   sync_fifo_param #(
      .DATA_W   (16),
      .DEPTH    (4),
      .AF_LEVEL (3),
      .AE_LEVEL (1),
      .FWFT     (1)
   ) u_dut1 (
      .clk          (clk),
      .reset        (reset),
      .write_e      (w1),
      .read_e       (r1),
      .data_in      (di1),
      .data_out     (do1),
      .full         (full1),
      .empty        (empty1),
      .almost_full  (af1),
      .almost_empty (ae1),
      .count        (cnt1),
      .overflow     (ovf1),
      .underflow    (udf1)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [7:0]  q0[$];
   logic [15:0] q1[$];
   logic [7:0]  exp_dout0;
   logic [15:0] exp_dout1;
   logic        exp_ovf0, exp_udf0, exp_ovf1, exp_udf1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      exp_dout0 = '0;
      exp_dout1 = '0;
      exp_ovf0  = 1'b0;
      exp_udf0  = 1'b0;
      exp_ovf1  = 1'b0;
      exp_udf1  = 1'b0;
   endtask

   // Apply one clock edge of the FIFO rules to the queues.
   task automatic model_edge();
      bit rd_ok, wr_ok;
      rd_ok = r0 && (q0.size() > 0);
      wr_ok = w0 && (q0.size() < 8 || rd_ok);
      exp_ovf0 = w0 && !wr_ok;
      exp_udf0 = r0 && !rd_ok;
      if (rd_ok) exp_dout0 = q0.pop_front();
      if (wr_ok) q0.push_back(di0);

      rd_ok = r1 && (q1.size() > 0);
      wr_ok = w1 && (q1.size() < 4 || rd_ok);
      exp_ovf1 = w1 && !wr_ok;
      exp_udf1 = r1 && !rd_ok;
      if (rd_ok) void'(q1.pop_front());
      if (wr_ok) q1.push_back(di1);
      exp_dout1 = (q1.size() > 0) ? q1[0] : 16'h0000;
   endtask

   task automatic check_all(input string tag);
      check({tag, "_d0_dout"},  32'(do0),    32'(exp_dout0));
      check({tag, "_d0_count"}, 32'(cnt0),   32'(q0.size()));
      check({tag, "_d0_full"},  32'(full0),  32'(q0.size() == 8));
      check({tag, "_d0_empty"}, 32'(empty0), 32'(q0.size() == 0));
      check({tag, "_d0_af"},    32'(af0),    32'(q0.size() >= 6));
      check({tag, "_d0_ae"},    32'(ae0),    32'(q0.size() <= 2));
      check({tag, "_d0_ovf"},   32'(ovf0),   32'(exp_ovf0));
      check({tag, "_d0_udf"},   32'(udf0),   32'(exp_udf0));
      check({tag, "_d1_dout"},  32'(do1),    32'(exp_dout1));
      check({tag, "_d1_count"}, 32'(cnt1),   32'(q1.size()));
      check({tag, "_d1_full"},  32'(full1),  32'(q1.size() == 4));
      check({tag, "_d1_empty"}, 32'(empty1), 32'(q1.size() == 0));
      check({tag, "_d1_af"},    32'(af1),    32'(q1.size() >= 3));
      check({tag, "_d1_ae"},    32'(ae1),    32'(q1.size() <= 1));
      check({tag, "_d1_ovf"},   32'(ovf1),   32'(exp_ovf1));
      check({tag, "_d1_udf"},   32'(udf1),   32'(exp_udf1));
   endtask

   // One clock: inputs already driven, model the edge, sample 1 time unit later.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      w0 = 1'b0;
      r0 = 1'b0;
      w1 = 1'b0;
      r1 = 1'b0;
      check_all(tag);
   endtask

   task automatic op0(input string tag, input bit we, input bit re, input logic [7:0] d);
      w0 = we;
      r0 = re;
      di0 = d;
      step(tag);
   endtask

   task automatic op1(input string tag, input bit we, input bit re, input logic [15:0] d);
      w1 = we;
      r1 = re;
      di1 = d;
      step(tag);
   endtask

   initial begin
      logic [7:0] fill_vals [8];
      fill_vals = '{8'd1, 8'd9, 8'd7, 8'd3, 8'd4, 8'd6, 8'd8, 8'd10};

      reset = 1'b1;
      w0 = 1'b0; r0 = 1'b0; di0 = '0;
      w1 = 1'b0; r1 = 1'b0; di1 = '0;
      model_reset();
      #1;
      check_all("reset");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_all("post_reset");

      // Fill and drain with the standard-mode FIFO
      foreach (fill_vals[i]) op0("fill", 1'b1, 1'b0, fill_vals[i]);
      // Rejected write on full: overflow pulse, count held, 0xFF never stored
      op0("ovf", 1'b1, 1'b0, 8'hFF);
      op0("ovf_clear", 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) op0("drain", 1'b0, 1'b1, 8'h00);
      // Rejected read on empty: underflow pulse, data_out holds
      op0("udf", 1'b0, 1'b1, 8'h00);
      op0("udf_clear", 1'b0, 1'b0, 8'h00);
      // Read+write on empty: read rejected, write accepted
      op0("rw_empty", 1'b1, 1'b1, 8'h11);
      for (int i = 0; i < 7; i++) op0("refill", 1'b1, 1'b0, 8'(8'h20 + i));
      // Read+write on full: both accepted, 0x55 emerges last
      op0("rw_full", 1'b1, 1'b1, 8'h55);
      for (int i = 0; i < 8; i++) op0("drain2", 1'b0, 1'b1, 8'h00);

      // Wrap-around with occupancy held at 3
      for (int i = 0; i < 3; i++) op0("wrap_prime", 1'b1, 1'b0, 8'($urandom));
      for (int i = 0; i < 20; i++) op0("wrap", 1'b1, 1'b1, 8'($urandom));
      for (int i = 0; i < 3; i++) op0("wrap_drain", 1'b0, 1'b1, 8'h00);

      // FWFT: head word visible one cycle after the write, no read needed
      op1("fwft_wr", 1'b1, 1'b0, 16'hBEEF);
      op1("fwft_hold", 1'b0, 1'b0, 16'h0000);
      op1("fwft_rd", 1'b0, 1'b1, 16'h0000);
      op1("fwft_rw_empty", 1'b1, 1'b1, 16'h1357);
      for (int i = 0; i < 3; i++) op1("fwft_fill", 1'b1, 1'b0, 16'(16'hA000 + i));
      op1("fwft_ovf", 1'b1, 1'b0, 16'hFFFF);
      op1("fwft_rw_full", 1'b1, 1'b1, 16'h5555);
      for (int i = 0; i < 5; i++) op1("fwft_drain", 1'b0, 1'b1, 16'h0000);

      // Randomised traffic on both FIFOs: fill-biased then drain-biased phases
      for (int i = 0; i < 400; i++) begin
         bit fill_phase;
         fill_phase = ((i / 50) % 2) == 0;
         w0  = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         r0  = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         di0 = 8'($urandom);
         w1  = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         r1  = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         di1 = 16'($urandom);
         step("rand");
      end

      // Mid-operation reset: bring FIFO 0 to count 5, then reset between edges
      for (int i = 0; i < 9; i++) op0("pre_rst_drain", 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 5; i++) op0("pre_rst_fill", 1'b1, 1'b0, 8'(8'h60 + i));
      op1("pre_rst_fill1", 1'b1, 1'b0, 16'h7777);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_all("mid_reset");
      #2;
      reset = 1'b0;
      op0("after_rst_wr", 1'b1, 1'b0, 8'hA5);
      op0("after_rst_rd", 1'b0, 1'b1, 8'h00);
      op1("after_rst_wr1", 1'b1, 1'b0, 16'h1234);
      op1("after_rst_rd1", 1'b0, 1'b1, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sync_fifo_param
